open_border_scheme_ctrl: RTL
============================

OPEN_BORDER_SCHEME_CTRL -- requirements
Module: open_border_scheme_ctrl

Interface
REQ-001 Parameters SHALL be: ROW_WIDTH, default 100, pixels per row; COL_HEIGHT, default 100, rows per frame; PIX_BIT, default 8, pixel bits; MASK_WIDTH, default 7, mask width (fixed at 7; ROW_WIDTH and COL_HEIGHT >= 7).
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- frame_start  in  1  one-cycle pulse that starts a frame; honoured only in IDLE.
- pix_in_valid  in  1  source pixel valid.
- pix_in_data  in  PIX_BIT  source pixel, raster order.
- pix_in_ready  out  1  controller accepts a pixel.
- ctrl2buf_valid  out  1  push strobe to the row buffers.
- data_cu2bufcf  out  PIX_BIT  pixel pushed to the row buffers.
- sel_top_row  out  1  top-border mirror select.
- sel_btm_row  out  2  bottom-border mirror select.
- sel_right_col  out  2  right-border mirror select.
- sel_left_col  out  1  left-border mirror select.
- out_valid  out  1  window on p_m2f is a valid centred window.
- frame_done  out  1  one-cycle end-of-frame pulse.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, FILL, RUN, FLUSH and DONE; let D = 3*ROW_WIDTH+3 (the centre offset).
REQ-004 Acceptance SHALL be defined as acc = pix_in_valid & pix_in_ready; pix_in_ready SHALL be 1 only in FILL and RUN (combinational from state and push count).
REQ-005 Push count P SHALL be initialised to 0 by frame_start and incremented on every push.
- Push in FILL/RUN = acc.
- Push in FLUSH = every cycle, with data 0.
REQ-006 ctrl2buf_valid and data_cu2bufcf SHALL be registered, with 1-cycle latency from the push decision.
REQ-007 FSM transitions SHALL be:
- IDLE->FILL on frame_start.
- FILL->RUN when the push making P=D occurs.
- RUN->FLUSH when the push making P=ROW_WIDTH*COL_HEIGHT occurs.
- FLUSH->DONE when the push making P=ROW_WIDTH*COL_HEIGHT+D occurs.
- DONE->IDLE unconditionally after 1 cycle.
REQ-008 Centre counters (ccol 0..ROW_WIDTH-1, crow 0..COL_HEIGHT-1) SHALL start at (0,0) and advance on each push from P>=D onward (pushes in RUN and FLUSH); ccol SHALL wrap to 0 and increment crow.
REQ-009 Selects SHALL be registered and updated in the same cycle as the ctrl2buf_valid of the push they belong to:
- sel_top_row = (crow<3).
- sel_left_col = (ccol<3).
- sel_btm_row = 0 normally; 1 at crow=COL_HEIGHT-3; 2 at COL_HEIGHT-2; 3 at COL_HEIGHT-1.
- sel_right_col: same encoding using ccol against ROW_WIDTH.
REQ-010 Selects SHALL hold their value between pushes (stall).
REQ-011 out_valid SHALL be asserted exactly 1 cycle after each ctrl2buf_valid issued in RUN or FLUSH, giving exactly ROW_WIDTH*COL_HEIGHT out_valid pulses per frame.
REQ-012 frame_done SHALL be high for the single DONE cycle.
REQ-013 busy SHALL be high in FILL, RUN, FLUSH and DONE.
REQ-014 frame_start outside IDLE SHALL be ignored, with no counter disturbance.
REQ-015 Source stalls (pix_in_valid=0) in FILL/RUN SHALL produce no push, no counter change and ctrl2buf_valid=0.
REQ-016 FLUSH SHALL push on every cycle regardless of pix_in_valid.
REQ-017 If frame_start and frame_done coincide, frame_start SHALL be ignored (the FSM is in DONE, not IDLE).

Reset
REQ-018 Asynchronous assertion of reset SHALL immediately force:
- state=IDLE.
- P, ccol and crow = 0.
- ctrl2buf_valid, out_valid, frame_done and busy = 0.
- data_cu2bufcf = 0 and all selects = 0.
REQ-019 Reset mid-frame SHALL abandon the frame; after release the block SHALL wait in IDLE for frame_start, and no pushes SHALL occur.

Verification (ROW_WIDTH=8, COL_HEIGHT=8, D=27)
REQ-020 The bench SHALL cover the following directed scenarios:
- Full frame, pix_in_valid constant 1: 64 accepts.
  - Exactly 91 ctrl2buf_valid pulses.
  - First out_valid 1 cycle after the 28th push.
  - 64 out_valid pulses in total.
  - frame_done 1 cycle after the 91st push.
- Select sequence: on the push with centre (0,0), sel_top_row=1, sel_left_col=1, sel_btm_row=0, sel_right_col=0.
  - Centre (7,7) gives sel_btm_row=3, sel_right_col=3, sel_top_row=0, sel_left_col=0.
  - Centre (5,6) gives sel_btm_row=1, sel_right_col=2.
- Random pix_in_valid stalls (50%):
  - Identical push and select sequence versus the no-stall run.
  - ctrl2buf_valid=0 on every stall cycle.
- Reset asserted at the 40th push:
  - All outputs 0 asynchronously.
  - pix_in_ready=0 until the next frame_start.
  - The next frame matches the full-frame case.
- frame_start pulsed in RUN and on the DONE cycle:
  - No effect.
  - A frame_start pulsed 1 cycle after DONE starts a new frame with P=0.
- FLUSH with pix_in_valid=0: all 27 flush pushes still occur on consecutive cycles with data_cu2bufcf=0.

Source files
------------

// File: rtl/open_border_scheme_ctrl.sv
// Open-border mask scheme controller: streams a raster frame into the row buffers,
// pads the tail with zero pixels, and tracks the window centre to drive border mirror selects.
module open_border_scheme_ctrl #(
  parameter int ROW_WIDTH  = 100,
  parameter int COL_HEIGHT = 100,
  parameter int PIX_BIT    = 8,
  parameter int MASK_WIDTH = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               pix_in_valid,
  input  logic [PIX_BIT-1:0] pix_in_data,
  output logic               pix_in_ready,
  output logic               ctrl2buf_valid,
  output logic [PIX_BIT-1:0] data_cu2bufcf,
  output logic               sel_top_row,
  output logic [1:0]         sel_btm_row,
  output logic [1:0]         sel_right_col,
  output logic               sel_left_col,
  output logic               out_valid,
  output logic               frame_done,
  output logic               busy
);

  localparam int HALF = MASK_WIDTH / 2;
  localparam int D    = HALF * ROW_WIDTH + HALF;
  localparam int N    = ROW_WIDTH * COL_HEIGHT;
  localparam int PW   = $clog2(N + D + 1);
  localparam int CW   = $clog2(ROW_WIDTH);
  localparam int RW   = $clog2(COL_HEIGHT);

  localparam logic [PW-1:0] P_RUN   = PW'(D);
  localparam logic [PW-1:0] P_FLUSH = PW'(N);
  localparam logic [PW-1:0] P_DONE  = PW'(N + D);

  localparam logic [CW-1:0] COL_HALF = CW'(HALF);
  localparam logic [CW-1:0] COL_M3   = CW'(ROW_WIDTH - 3);
  localparam logic [CW-1:0] COL_M2   = CW'(ROW_WIDTH - 2);
  localparam logic [CW-1:0] COL_M1   = CW'(ROW_WIDTH - 1);
  localparam logic [RW-1:0] ROW_HALF = RW'(HALF);
  localparam logic [RW-1:0] ROW_M3   = RW'(COL_HEIGHT - 3);
  localparam logic [RW-1:0] ROW_M2   = RW'(COL_HEIGHT - 2);
  localparam logic [RW-1:0] ROW_M1   = RW'(COL_HEIGHT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t             state, state_next;
  logic [PW-1:0]      p_cnt;
  logic [PW-1:0]      p_inc;
  logic [CW-1:0]      ccol;
  logic [RW-1:0]      crow;
  logic               push;
  logic               centre_push;
  logic               centre_q;
  logic [PIX_BIT-1:0] push_data;

  assign p_inc        = p_cnt + 1'b1;
  assign pix_in_ready = (state == S_FILL) || (state == S_RUN);
  assign centre_push  = push && ((state == S_RUN) || (state == S_FLUSH));
  assign frame_done   = (state == S_DONE);
  assign busy         = (state != S_IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    push_data  = '0;
    unique case (state)
      S_IDLE: if (frame_start) state_next = S_FILL;
      S_FILL: begin
        push      = pix_in_valid;
        push_data = pix_in_data;
        if (push && p_inc == P_RUN) state_next = S_RUN;
      end
      S_RUN: begin
        push      = pix_in_valid;
        push_data = pix_in_data;
        if (push && p_inc == P_FLUSH) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        push = 1'b1;
        if (p_inc == P_DONE) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Selects describe the centre of the window the push completes; they hold across stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_cnt          <= '0;
      ccol           <= '0;
      crow           <= '0;
      ctrl2buf_valid <= 1'b0;
      centre_q       <= 1'b0;
      out_valid      <= 1'b0;
      data_cu2bufcf  <= '0;
      sel_top_row    <= 1'b0;
      sel_btm_row    <= 2'd0;
      sel_right_col  <= 2'd0;
      sel_left_col   <= 1'b0;
    end else begin
      ctrl2buf_valid <= push;
      centre_q       <= centre_push;
      out_valid      <= centre_q;
      if (state == S_IDLE && frame_start) begin
        p_cnt <= '0;
        ccol  <= '0;
        crow  <= '0;
      end else if (push) begin
        p_cnt         <= p_inc;
        data_cu2bufcf <= push_data;
        sel_top_row   <= (crow < ROW_HALF);
        sel_left_col  <= (ccol < COL_HALF);
        sel_btm_row   <= (crow == ROW_M3) ? 2'd1 : (crow == ROW_M2) ? 2'd2 :
                         (crow == ROW_M1) ? 2'd3 : 2'd0;
        sel_right_col <= (ccol == COL_M3) ? 2'd1 : (ccol == COL_M2) ? 2'd2 :
                         (ccol == COL_M1) ? 2'd3 : 2'd0;
        if (centre_push) begin
          if (ccol == COL_M1) begin
            ccol <= '0;
            crow <= (crow == ROW_M1) ? '0 : crow + 1'b1;
          end else begin
            ccol <= ccol + 1'b1;
          end
        end
      end
    end
  end

endmodule
